// File: rtl/uv_bpu_bht.sv
// Fetch-stage branch predictor: pre-decodes the fetched instruction, predicts
// the next PC from a 2-bit-counter BHT (static BTFN fallback), issues the reset PC.
module uv_bpu_bht #(
  parameter int unsigned ALEN      = 32,
  parameter int unsigned ILEN      = 32,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned BHT_EN    = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ALEN-1:0]   rst_pc,
  input  logic              if2bp_vld,
  input  logic [ALEN-1:0]   if2bp_pc,
  input  logic [ILEN-1:0]   if2bp_inst,
  output logic [4:0]        bp2rf_rd_idx,
  input  logic [XLEN-1:0]   bp2rf_rd_data,
  input  logic              bp2rf_rd_rdy,
  input  logic              ex2bp_upd_vld,
  input  logic [ALEN-1:0]   ex2bp_upd_pc,
  input  logic              ex2bp_upd_tak,
  input  logic              ex2bp_upd_mis,
  input  logic              bp_flush,
  output logic              bp2if_pc_vld,
  output logic [ALEN-1:0]   bp2if_pc_nxt,
  output logic              bp2if_br_tak,
  output logic              bp2if_stall,
  output logic [CNT_W-1:0]  bp_mis_cnt
);

  localparam int unsigned IW = $clog2(BHT_DEPTH);

  logic [2:0]       rst_sr_q, rst_sr_d;
  logic [ALEN-1:0]  rst_pc_q;
  logic             rst_pulse;

  logic [6:0]       opc;
  logic             is_bjp, is_jal, is_jalr, is_br;
  logic [ALEN-1:0]  i_imm, b_imm, j_imm;
  logic [ALEN-1:0]  rs1_a, jalr_sum;

  logic             bht_vld_q [BHT_DEPTH];
  logic [1:0]       bht_cnt_q [BHT_DEPTH];
  logic [IW-1:0]    lk_idx, upd_idx;
  logic             upd_en;
  logic [1:0]       upd_cnt;
  logic             lk_vld;
  logic [1:0]       lk_cnt;
  logic             taken;

  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

  // Reset-PC sequencer: one-hot walks 001 -> 010 -> 100 -> 000 and stays there.
  assign rst_sr_d  = {rst_sr_q[1:0], 1'b0};
  assign rst_pulse = rst_sr_q[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sr_q <= 3'b001;
      rst_pc_q <= '0;
    end else begin
      rst_sr_q <= rst_sr_d;
      rst_pc_q <= rst_pc;
    end
  end

  assign opc     = if2bp_inst[6:0];
  assign is_bjp  = (opc[6:4] == 3'b110);
  assign is_jal  = is_bjp & (opc[3:2] == 2'b11);
  assign is_jalr = is_bjp & (opc[3:2] == 2'b01);
  assign is_br   = is_bjp & (opc[3:2] == 2'b00);

  assign i_imm = {{(ALEN-12){if2bp_inst[31]}}, if2bp_inst[31:20]};
  assign b_imm = {{(ALEN-12){if2bp_inst[31]}}, if2bp_inst[7], if2bp_inst[30:25],
                  if2bp_inst[11:8], 1'b0};
  assign j_imm = {{(ALEN-20){if2bp_inst[31]}}, if2bp_inst[19:12], if2bp_inst[20],
                  if2bp_inst[30:21], 1'b0};

  assign bp2rf_rd_idx = if2bp_inst[19:15];

  if (XLEN >= ALEN) begin : g_rs1_trunc
    assign rs1_a = bp2rf_rd_data[ALEN-1:0];
    if (XLEN > ALEN) begin : g_rs1_hi
      logic unused_rs1_hi;
      assign unused_rs1_hi = ^bp2rf_rd_data[XLEN-1:ALEN];
    end
  end else begin : g_rs1_zext
    assign rs1_a = {{(ALEN-XLEN){1'b0}}, bp2rf_rd_data};
  end

  if (ILEN > 32) begin : g_inst_hi
    logic unused_inst_hi;
    assign unused_inst_hi = ^if2bp_inst[ILEN-1:32];
  end

  assign jalr_sum = rs1_a + i_imm;

  assign lk_idx  = if2bp_pc[IW+1:2];
  assign upd_idx = ex2bp_upd_pc[IW+1:2];
  assign upd_en  = (BHT_EN != 0) & ex2bp_upd_vld & ~bp_flush;

  always_comb begin
    upd_cnt = ex2bp_upd_tak ? 2'b10 : 2'b01;
    if (bht_vld_q[upd_idx]) begin
      if (ex2bp_upd_tak)
        upd_cnt = (bht_cnt_q[upd_idx] == 2'b11) ? 2'b11 : bht_cnt_q[upd_idx] + 2'b01;
      else
        upd_cnt = (bht_cnt_q[upd_idx] == 2'b00) ? 2'b00 : bht_cnt_q[upd_idx] - 2'b01;
    end
  end

  // Lookup sees the entry as it will be after this edge's update or flush.
  always_comb begin
    lk_vld = bht_vld_q[lk_idx];
    lk_cnt = bht_cnt_q[lk_idx];
    if (upd_en && (upd_idx == lk_idx)) begin
      lk_vld = 1'b1;
      lk_cnt = upd_cnt;
    end
    if (bp_flush) lk_vld = 1'b0;
  end

  assign taken = ((BHT_EN != 0) && lk_vld) ? lk_cnt[1] : if2bp_inst[31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
        bht_vld_q[i] <= 1'b0;
        bht_cnt_q[i] <= 2'b01;
      end
    end else if (bp_flush) begin
      for (int unsigned i = 0; i < BHT_DEPTH; i++) bht_vld_q[i] <= 1'b0;
    end else if (upd_en) begin
      bht_vld_q[upd_idx] <= 1'b1;
      bht_cnt_q[upd_idx] <= upd_cnt;
    end
  end

  always_comb begin
    bp2if_pc_nxt = if2bp_pc + ALEN'(4);
    if (rst_pulse)             bp2if_pc_nxt = rst_pc_q;
    else if (is_jal)           bp2if_pc_nxt = if2bp_pc + j_imm;
    else if (is_jalr)          bp2if_pc_nxt = {jalr_sum[ALEN-1:1], 1'b0};
    else if (is_br && taken)   bp2if_pc_nxt = if2bp_pc + b_imm;
  end

  assign bp2if_stall  = rst_n & ~rst_pulse & if2bp_vld & is_jalr & ~bp2rf_rd_rdy;
  assign bp2if_pc_vld = rst_pulse | (rst_n & if2bp_vld & ~bp2if_stall);
  assign bp2if_br_tak = rst_n & ~rst_pulse & is_br & taken;

  assign mis_cnt_d = (ex2bp_upd_vld && ex2bp_upd_mis && !(&mis_cnt_q))
                   ? mis_cnt_q + CNT_W'(1) : mis_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mis_cnt_q <= '0;
    else        mis_cnt_q <= mis_cnt_d;
  end

  assign bp_mis_cnt = mis_cnt_q;

  logic unused_bits;
  assign unused_bits = ^{if2bp_inst[14:12], if2bp_inst[1:0],
                         ex2bp_upd_pc[ALEN-1:IW+2], ex2bp_upd_pc[1:0]};

endmodule

// File: tb/tb_uv_bpu_bht.sv
// Randomised self-checking bench for uv_bpu_bht: a BHT-enabled instance (CNT_W=2)
// and a static-BTFN instance share stimulus and are compared to an array model.
module tb_uv_bpu_bht;

  localparam int K_OTH = 0, K_BR = 1, K_JAL = 2, K_JALR = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rst_pc;
  logic        if2bp_vld;
  logic [31:0] if2bp_pc, if2bp_inst;
  logic [31:0] rd_data;
  logic        rd_rdy;
  logic        upd_vld, upd_tak, upd_mis, flush;
  logic [31:0] upd_pc;

  logic [4:0]  rd_idx0, rd_idx1;
  logic        pc_vld0, pc_vld1, br_tak0, br_tak1, stall0, stall1;
  logic [31:0] pc_nxt0, pc_nxt1;
  logic [1:0]  mis0;
  logic [15:0] mis1;

  int          n_checks = 0;
  int          n_errors = 0;

  // bench-side view of the current fetch
  int          f_kind;
  int          f_imm;
  bit          exp_pulse = 0;

  // reference model state (instance 0 table, both miss counters)
  bit          m_vld [64];
  int          m_cnt [64];
  int          m_mis0, m_mis1;

  always #5 clk = ~clk;

  uv_bpu_bht #(.ALEN(32), .ILEN(32), .XLEN(32), .BHT_DEPTH(64), .BHT_EN(1), .CNT_W(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .rst_pc(rst_pc),
    .if2bp_vld(if2bp_vld), .if2bp_pc(if2bp_pc), .if2bp_inst(if2bp_inst),
    .bp2rf_rd_idx(rd_idx0), .bp2rf_rd_data(rd_data), .bp2rf_rd_rdy(rd_rdy),
    .ex2bp_upd_vld(upd_vld), .ex2bp_upd_pc(upd_pc), .ex2bp_upd_tak(upd_tak),
    .ex2bp_upd_mis(upd_mis), .bp_flush(flush),
    .bp2if_pc_vld(pc_vld0), .bp2if_pc_nxt(pc_nxt0), .bp2if_br_tak(br_tak0),
    .bp2if_stall(stall0), .bp_mis_cnt(mis0)
  );

  uv_bpu_bht #(.ALEN(32), .ILEN(32), .XLEN(32), .BHT_DEPTH(64), .BHT_EN(0), .CNT_W(16)) u_static (
    .clk(clk), .rst_n(rst_n), .rst_pc(rst_pc),
    .if2bp_vld(if2bp_vld), .if2bp_pc(if2bp_pc), .if2bp_inst(if2bp_inst),
    .bp2rf_rd_idx(rd_idx1), .bp2rf_rd_data(rd_data), .bp2rf_rd_rdy(rd_rdy),
    .ex2bp_upd_vld(upd_vld), .ex2bp_upd_pc(upd_pc), .ex2bp_upd_tak(upd_tak),
    .ex2bp_upd_mis(upd_mis), .bp_flush(flush),
    .bp2if_pc_vld(pc_vld1), .bp2if_pc_nxt(pc_nxt1), .bp2if_br_tak(br_tak1),
    .bp2if_stall(stall1), .bp_mis_cnt(mis1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_b(input int imm);
    logic [31:0] x;
    x = imm;
    return {x[12], x[10:5], 5'd2, 5'd3, 3'b000, x[4:1], x[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input int imm);
    logic [31:0] x;
    x = imm;
    return {x[20], x[10:1], x[11], x[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr(input int imm, input logic [4:0] rs1);
    logic [31:0] x;
    x = imm;
    return {x[11:0], rs1, 3'b000, 5'd1, 7'b1100111};
  endfunction

  function automatic int sat_step(input bit v, input int c, input bit tak);
    int n;
    if (!v) return tak ? 2 : 1;
    n = tak ? c + 1 : c - 1;
    if (n > 3) n = 3;
    if (n < 0) n = 0;
    return n;
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  task automatic set_fetch(input int kind, input logic [31:0] pc, input int imm,
                           input logic [31:0] rs1v, input bit rdy);
    logic [31:0] r;
    f_kind = kind; f_imm = imm;
    if2bp_vld = 1'b1; if2bp_pc = pc; rd_data = rs1v; rd_rdy = rdy;
    r = $urandom();
    case (kind)
      K_BR:    if2bp_inst = enc_b(imm);
      K_JAL:   if2bp_inst = enc_j(imm);
      K_JALR:  if2bp_inst = enc_jalr(imm, r[4:0]);
      default: if2bp_inst = {r[31:7], 7'b0010011};
    endcase
  endtask

  task automatic idle_fetch();
    set_fetch(K_OTH, 32'h0, 0, 32'h0, 1'b1);
    if2bp_vld = 1'b0;
  endtask

  task automatic set_upd(input bit v, input logic [31:0] pc, input bit tak, input bit mis);
    upd_vld = v; upd_pc = pc; upd_tak = tak; upd_mis = mis;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin m_vld[i] = 0; m_cnt[i] = 1; end
    m_mis0 = 0; m_mis1 = 0;
  endtask

  function automatic logic [31:0] exp_next(input bit tk);
    case (f_kind)
      K_BR:    return tk ? if2bp_pc + 32'(f_imm) : if2bp_pc + 32'd4;
      K_JAL:   return if2bp_pc + 32'(f_imm);
      K_JALR:  return (rd_data + 32'(f_imm)) & ~32'd1;
      default: return if2bp_pc + 32'd4;
    endcase
  endfunction

  // Check every output against the model, then advance one clock and commit.
  task automatic step();
    bit   v, tk0, tk1, e_stall, e_vld;
    int   c, i;
    logic [31:0] e0, e1, inst;
    #3;
    inst = if2bp_inst;
    chk("rd_idx0", 64'(rd_idx0), 64'(inst[19:15]));
    chk("rd_idx1", 64'(rd_idx1), 64'(inst[19:15]));
    chk("mis0", 64'(mis0), 64'(m_mis0));
    chk("mis1", 64'(mis1), 64'(m_mis1));
    if (!rst_n) begin
      chk("rst_vld0", 64'(pc_vld0), 64'd0);
      chk("rst_tak0", 64'(br_tak0), 64'd0);
      chk("rst_stall0", 64'(stall0), 64'd0);
      chk("rst_vld1", 64'(pc_vld1), 64'd0);
    end else begin
      i = idx_of(if2bp_pc);
      v = m_vld[i]; c = m_cnt[i];
      if (upd_vld && idx_of(upd_pc) == i) begin c = sat_step(v, c, upd_tak); v = 1; end
      if (flush) v = 0;
      tk0 = v ? (c >= 2) : (f_imm < 0);
      tk1 = (f_imm < 0);
      e_stall = !exp_pulse && if2bp_vld && f_kind == K_JALR && !rd_rdy;
      e_vld = exp_pulse || (if2bp_vld && !e_stall);
      e0 = exp_pulse ? rst_pc : exp_next(tk0);
      e1 = exp_pulse ? rst_pc : exp_next(tk1);
      chk("pc_vld0", 64'(pc_vld0), 64'(e_vld));
      chk("pc_vld1", 64'(pc_vld1), 64'(e_vld));
      chk("stall0", 64'(stall0), 64'(e_stall));
      chk("stall1", 64'(stall1), 64'(e_stall));
      if (!exp_pulse) begin
        chk("br_tak0", 64'(br_tak0), 64'(f_kind == K_BR && tk0));
        chk("br_tak1", 64'(br_tak1), 64'(f_kind == K_BR && tk1));
      end
      if (e_vld) begin
        chk("pc_nxt0", 64'(pc_nxt0), 64'(e0));
        chk("pc_nxt1", 64'(pc_nxt1), 64'(e1));
      end
    end
    @(posedge clk);
    if (rst_n) begin
      if (flush) begin
        for (int k = 0; k < 64; k++) m_vld[k] = 0;
      end else if (upd_vld) begin
        i = idx_of(upd_pc);
        m_cnt[i] = sat_step(m_vld[i], m_cnt[i], upd_tak);
        m_vld[i] = 1;
      end
      if (upd_vld && upd_mis) begin
        if (m_mis0 < 3) m_mis0++;
        if (m_mis1 < 65535) m_mis1++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    idle_fetch();
    set_upd(0, 32'h0, 0, 0);
    flush = 1'b0;
    #1;
    chk("async_mis0", 64'(mis0), 64'd0);
    chk("async_vld0", 64'(pc_vld0), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    exp_pulse = 0; step();
    exp_pulse = 0; step();
    exp_pulse = 1; step();
    exp_pulse = 0; step();
  endtask

  initial begin
    rst_n = 1'b1;
    rst_pc = 32'h8000_0000;
    idle_fetch();
    set_upd(0, 32'h0, 0, 0);
    flush = 1'b0;
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // cold forward branch at 0x100, then train taken twice
    set_fetch(K_BR, 32'h100, 32, 32'h0, 1'b1);
    #3; chk("cold_fwd_pc", 64'(pc_nxt0), 64'h104); chk("cold_fwd_tak", 64'(br_tak0), 64'd0);
    step();
    idle_fetch(); set_upd(1, 32'h100, 1, 0); step(); step();
    set_upd(0, 32'h0, 0, 0);
    set_fetch(K_BR, 32'h100, 32, 32'h0, 1'b1);
    #3; chk("hot_fwd_pc", 64'(pc_nxt0), 64'h120); chk("hot_fwd_tak", 64'(br_tak0), 64'd1);
    step();

    // saturate down, one taken -> weakly not-taken
    idle_fetch(); set_upd(1, 32'h100, 0, 0);
    repeat (4) step();
    set_upd(1, 32'h100, 1, 0); step();
    set_upd(0, 32'h0, 0, 0);
    set_fetch(K_BR, 32'h100, 32, 32'h0, 1'b1);
    #3; chk("sat_pc", 64'(pc_nxt0), 64'h104);
    step();

    // bypass: update index 5 while fetching a backward branch at index 5
    set_upd(1, 32'h14, 0, 0);
    set_fetch(K_BR, 32'h14, -16, 32'h0, 1'b1);
    #3; chk("bypass_pc", 64'(pc_nxt0), 64'h18); chk("bypass_static", 64'(pc_nxt1), 64'h4);
    step();
    set_upd(0, 32'h0, 0, 0);

    // JALR waits on rs1
    set_fetch(K_JALR, 32'h500, 4, 32'h2001, 1'b0);
    repeat (3) begin
      #3; chk("jalr_stall", 64'(stall0), 64'd1); chk("jalr_nvld", 64'(pc_vld0), 64'd0);
      step();
    end
    rd_rdy = 1'b1;
    #3; chk("jalr_pc", 64'(pc_nxt0), 64'h2004); chk("jalr_vld", 64'(pc_vld0), 64'd1);
    step();

    // train backward branch not-taken, then flush together with an update
    idle_fetch(); set_upd(1, 32'h40, 0, 0); step(); step();
    set_upd(0, 32'h0, 0, 0);
    set_fetch(K_BR, 32'h40, -32, 32'h0, 1'b1);
    #3; chk("trained_nt", 64'(pc_nxt0), 64'h44); chk("static_bwd", 64'(pc_nxt1), 64'h20);
    step();
    flush = 1'b1; set_upd(1, 32'h40, 0, 0);
    #3; chk("flush_lookup", 64'(pc_nxt0), 64'h20);
    step();
    flush = 1'b0; set_upd(0, 32'h0, 0, 0);
    #3; chk("post_flush", 64'(pc_nxt0), 64'h20);
    step();

    // misprediction counter saturation
    idle_fetch(); set_upd(1, 32'h300, 1, 1);
    repeat (5) step();
    set_upd(0, 32'h0, 0, 0);
    #3; chk("mis_sat", 64'(mis0), 64'd3);
    step();

    // randomised traffic over a small aliasing PC window
    for (int n = 0; n < 400; n++) begin
      int kind, imm;
      logic [31:0] pc;
      kind = $urandom_range(0, 3);
      pc = 32'h1000 + ($urandom_range(0, 255) << 2);
      case (kind)
        K_BR:    imm = $urandom_range(0, 4095) * 2 - 4096;
        K_JAL:   imm = $urandom_range(0, 1048575) * 2 - 1048576;
        K_JALR:  imm = $urandom_range(0, 4095) - 2048;
        default: imm = 0;
      endcase
      set_fetch(kind, pc, imm, $urandom(), $urandom_range(0, 1) == 1);
      if2bp_vld = ($urandom_range(0, 3) != 0);
      set_upd($urandom_range(0, 1) == 1, 32'h1000 + ($urandom_range(0, 255) << 2),
              $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 19) == 0);
      step();
    end
    flush = 1'b0; set_upd(0, 32'h0, 0, 0);

    // asynchronous reset mid-run with a new reset PC
    rst_pc = 32'h4000_0000;
    do_reset();
    set_fetch(K_BR, 32'h40, -32, 32'h0, 1'b1);
    #3; chk("reset_cleared", 64'(pc_nxt0), 64'h20);
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uv_bpu_bht.md
# uv_bpu_bht

Parametrised dynamic branch prediction unit for the uv core fetch stage. It pre-decodes the fetched instruction and produces the next PC in the same cycle. Conditional branches are predicted from a direct-mapped branch history table (BHT) of 2-bit saturating counters, which the execution unit trains. Branches that miss in the table fall back to static BTFN, and the block also issues the post-reset PC and counts mispredictions.

## Interface
- ALEN, 32, address width (≥ 21)
- ILEN, 32, instruction width
- XLEN, 32, register width
- BHT_DEPTH, 64, BHT entries; power of 2, 2..1024
- BHT_EN, 1, 0 = pure static BTFN; table and update port are ignored
- CNT_W, 16, misprediction counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- rst_pc  in  ALEN  PC after reset
- if2bp_vld  in  1  fetched instruction valid
- if2bp_pc  in  ALEN  PC of fetched instruction
- if2bp_inst  in  ILEN  fetched instruction
- bp2rf_rd_idx  out  5  rs1 index, always if2bp_inst[19:15]
- bp2rf_rd_data  in  XLEN  rs1 value, already forwarded
- bp2rf_rd_rdy  in  1  rs1 value current (no pending writer)
- ex2bp_upd_vld  in  1  resolved conditional branch
- ex2bp_upd_pc  in  ALEN  PC of resolved branch
- ex2bp_upd_tak  in  1  actual direction
- ex2bp_upd_mis  in  1  direction was mispredicted
- bp_flush  in  1  invalidate whole BHT
- bp2if_pc_vld  out  1  next PC valid
- bp2if_pc_nxt  out  ALEN  predicted next PC
- bp2if_br_tak  out  1  conditional branch predicted taken
- bp2if_stall  out  1  JALR waiting for rs1
- bp_mis_cnt  out  CNT_W  saturating misprediction count

## Operation
- Pre-decode: opcode[6:4]==110 is BJP. With opcode[3:2]: 11 = JAL, 01 = JALR, 00 = branch. Immediates use RISC-V I/B/J formats, sign-extended to ALEN; B and J have an implicit bit 0 = 0.
- Index is IW = log2(BHT_DEPTH) bits wide, taken from pc[IW+1:2], for both lookup and update. Each entry holds valid + cnt[1:0].
- Branch direction: if BHT_EN and the entry is valid, taken = cnt[1]. Otherwise taken = imm sign (BTFN).
- Next PC:
  - Non-BJP or not-taken branch: pc+4.
  - Taken branch: pc+b_imm.
  - JAL: pc+j_imm.
  - JALR: (rs1+i_imm) with bit 0 cleared. Width-adapt rs1 by zero-extending or truncating to ALEN.
- bp2if_br_tak = branch & taken; it is 0 for JAL, JALR and non-BJP.
- JALR stall: if2bp_vld & JALR & ~bp2rf_rd_rdy gives bp2if_stall=1 and bp2if_pc_vld=0. IFU holds its inputs until rd_rdy.
- bp2if_pc_vld = rst-PC pulse | (if2bp_vld & ~bp2if_stall).
- Update, only when BHT_EN:
  - Valid entry: taken increments cnt, saturating at 3; not-taken decrements, saturating at 0.
  - Invalid entry: set valid, cnt = tak ? 2'b10 : 2'b01.
  - The update writes on the clock edge.
- Flush clears all valid bits at the edge. Flush together with an update: flush wins and the update is discarded.
- bp_mis_cnt increments on ex2bp_upd_vld & ex2bp_upd_mis and saturates at all-ones. It is independent of BHT_EN.

## Timing
- Reset values:
  - bp2if_pc_vld=0, bp2if_br_tak=0, bp2if_stall=0, bp_mis_cnt=0.
  - All BHT entries valid=0, cnt=01.
  - Internal reset shift register = 3'b001.
- rst_pc is registered every cycle. After rst_n deasserts, the shift register goes 001→010→100→000. While it is 100 (after the 2nd rising edge), bp2if_pc_vld=1 and pc_nxt = registered rst_pc, overriding if2bp inputs. This lasts exactly one cycle and occurs once per reset.
- Prediction is combinational: zero-cycle latency from if2bp_* and bp2rf_rd_* to outputs.
- Update/flush take effect on the next rising edge.
- Same-cycle lookup of an index being updated: lookup returns the post-update value (bypass). Under flush it returns invalid.
- Asserting rst_n low mid-operation asynchronously clears the table, counters and outputs, and restarts the reset-PC sequence.

## Test plan
- Reset, rst_pc=0x8000_0000 → exactly one pc_vld pulse, pc_nxt=0x8000_0000, 2 edges after release; pc_vld=0 for the other cycles of the first 4.
- Invalid-entry forward branch at 0x100, imm=+0x20 → pc_nxt=0x104, br_tak=0. Then 2 updates tak=1 → cnt=11; next fetch gives pc_nxt=0x120, br_tak=1.
- Saturation: 4 not-taken updates then 1 taken update → cnt 00→01, predict not-taken. Updating index 5 with the same-cycle lookup of index 5 → bypassed value used.
- JALR with rs1=0x2001, imm=+4, rd_rdy=0 for 3 cycles → stall=1, pc_vld=0. Then rd_rdy=1 → pc_nxt=0x2004, pc_vld=1.
- bp_flush together with an update → entry invalid next cycle, BTFN prediction. With BHT_EN=0, a trained backward branch is still predicted taken.
- CNT_W=2, 5 mispredict updates → bp_mis_cnt=3 and held. Async rst_n mid-run → counter 0.
